// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the scoreboarded register file.
// master = decode/writeback side, slave = reg_file_sb.
interface reg_file_sb_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic              rs1_busy;
   logic              rs2_busy;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rsv_ready;
   logic              flush;
   logic [DEPTH-1:0]  busy_vec;

   modport master (
      output rs1_addr, rs2_addr, wr_en, rd_addr, rd_data, rsv_en, rsv_addr, flush,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ready, busy_vec
   );

   modport slave (
      input  rs1_addr, rs2_addr, wr_en, rd_addr, rd_data, rsv_en, rsv_addr, flush,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ready, busy_vec
   );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, two read ports, one write port.
// Latency: reads combinational (optional write bypass); write/reserve/flush land on the edge.
// Backpressure: rsv_ready low drops the reserve; requester holds and retries.
module reg_file_sb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_file_sb_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   logic wr_ok;
   logic rsv_acc;
   logic hit1;
   logic hit2;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Writes are masked while reset is held so the bypass path is dead too.
   assign wr_ok = bus.wr_en & rst_n & ~is_zero(bus.rd_addr);
   assign hit1  = (BYPASS != 0) && wr_ok && (bus.rd_addr == bus.rs1_addr);
   assign hit2  = (BYPASS != 0) && wr_ok && (bus.rd_addr == bus.rs2_addr);

   always_comb begin
      bus.rs1_data = is_zero(bus.rs1_addr) ? '0 : regs_q[bus.rs1_addr];
      bus.rs2_data = is_zero(bus.rs2_addr) ? '0 : regs_q[bus.rs2_addr];
      bus.rs1_busy = busy_q[bus.rs1_addr];
      bus.rs2_busy = busy_q[bus.rs2_addr];
      if (hit1) begin
         bus.rs1_data = bus.rd_data;
         bus.rs1_busy = 1'b0;
      end
      if (hit2) begin
         bus.rs2_data = bus.rd_data;
         bus.rs2_busy = 1'b0;
      end
   end

   // A writeback retiring the old producer frees the slot for a new one this cycle.
   assign bus.rsv_ready = ~busy_q[bus.rsv_addr] | (wr_ok & (bus.rd_addr == bus.rsv_addr));
   assign rsv_acc       = bus.rsv_en & bus.rsv_ready & rst_n & ~is_zero(bus.rsv_addr);
   assign bus.busy_vec  = busy_q;

   always_comb begin
      busy_d = bus.flush ? '0 : busy_q;
      if (wr_ok)   busy_d[bus.rd_addr]  = 1'b0;
      if (rsv_acc) busy_d[bus.rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         busy_q <= busy_d;
         if (wr_ok) regs_q[bus.rd_addr] <= bus.rd_data;
      end
   end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with integrated scoreboard for the 8-bit core; the successor to the current 8×8 register file. Provides two combinational read ports, one synchronous write port with same-cycle write-through bypass, and per-register busy bits so decode can detect pending writebacks and stall. Sits between decode (read/reserve) and writeback (write); width, depth and an optional hardwired-zero register are set by parameter.

## Interface
- DATA_W, 8, data width of each register
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs1_addr  in  ADDR_W  read port 1 address
- rs2_addr  in  ADDR_W  read port 2 address
- rs1_data  out  DATA_W  read port 1 data (combinational)
- rs2_data  out  DATA_W  read port 2 data (combinational)
- rs1_busy  out  1  register at rs1_addr has a pending write
- rs2_busy  out  1  register at rs2_addr has a pending write
- wr_en  in  1  writeback strobe
- rd_addr  in  ADDR_W  writeback address
- rd_data  in  DATA_W  writeback data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  destination to reserve
- rsv_ready  out  1  !busy[rsv_addr]; reservation accepted when rsv_en & rsv_ready
- flush  in  1  clear all busy bits (data untouched)
- busy_vec  out  DEPTH  all busy bits, bit i = register i

## Operation
- Storage: DEPTH × DATA_W flops plus DEPTH busy flops; no latch inference, no read/write mode pin.
- Read: rsN_data = regs[rsN_addr]; if BYPASS and wr_en and rd_addr == rsN_addr, rsN_data = rd_data and rsN_busy = 0.
- rsN_busy = busy[rsN_addr], subject to bypass rule above.
- Write: on clk edge with wr_en, regs[rd_addr] <= rd_data; busy[rd_addr] <= 0. Writing a non-busy register is legal; busy stays 0.
- Reserve: on clk edge with rsv_en & rsv_ready, busy[rsv_addr] <= 1. rsv_en with rsv_ready = 0 is dropped (no state change); requester must hold and retry.
- Same-cycle write + reserve to same address: data written, busy ends 1 (new producer wins). rsv_ready for that cycle reflects pre-edge busy plus the write: rsv_ready = !busy[rsv_addr] | (wr_en & rd_addr == rsv_addr).
- flush: on clk edge all busy <= 0; a same-cycle accepted reserve still sets its bit (reserve after flush). Same-cycle write still updates data.
- ZERO_REG = 1: address 0 reads 0, write data discarded, busy[0] constant 0, rsv_ready = 1 for address 0, bypass suppressed for address 0.
- Both read ports may hit the same address, including the write address; both see identical data.

## Timing
- Reset (reset = 0): immediately, independent of clk, all registers = 0 and all busy = 0; rs1/rs2_data = 0, rs1/rs2_busy = 0, busy_vec = 0, rsv_ready = 1. All write/reserve/flush inputs ignored while asserted; bypass disabled.
- Reset release: first rising edge with reset = 1 accepts writes and reserves.
- Read latency 0 cycles (combinational from address). Write-to-read latency 0 with BYPASS = 1, 1 cycle with BYPASS = 0.
- Reserve-to-busy visible: next cycle. Write clears busy at the edge; with BYPASS the read port sees not-busy in the write cycle.
- Reset asserted mid-operation aborts all pending reservations; no partial write.

## Test plan
- Reset: load regs 1..7 with 0x11..0x77, pull reset low between edges -> all rsN_data = 0x00, busy_vec = 0 immediately, before next edge.
- Write/read: wr_en, rd_addr = 5, rd_data = 0xA5; next cycle rs1_addr = rs2_addr = 5 -> both 0xA5; with BYPASS = 1, same cycle rs1_addr = 5 -> 0xA5.
- Scoreboard: reserve 3 -> next cycle rs1_busy = 1 at addr 3, busy_vec = 0x08, rsv_ready = 0 for addr 3; second rsv_en to 3 dropped; write 3 = 0x3C -> same cycle rs1_busy = 0, data 0x3C; next cycle busy_vec = 0x00.
- Collision: busy[4] = 1, same edge wr_en addr 4 = 0x44 and rsv_en addr 4 -> regs[4] = 0x44, busy[4] = 1 after edge; rsv accepted.
- Flush: busy_vec = 0x2C, flush with rsv_en addr 1 -> busy_vec = 0x02; data unchanged.
- ZERO_REG = 1, DATA_W = 16, ADDR_W = 4: write 0xBEEF to reg 0 -> reads 0x0000, busy[0] stays 0; write reg 15 = 0xBEEF -> reads 0xBEEF.
